// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer (fetch / decode / execute, T0..T7)
// for the 32-bit bus-based datapath. Strobes are a decode of the state
// register and the opcode latched at the end of T2.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic        stop,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        mem_done,
    output logic        PCout,
    output logic        ZHighout,
    output logic        ZLowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        ZHIin,
    output logic        ZLOin,
    output logic        HIin,
    output logic        LOin,
    output logic        CONin,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  operation,
    output logic        Run
);

    localparam int unsigned OP_W = 5;

    localparam logic [3:0] RESET = 4'd0;
    localparam logic [3:0] T0    = 4'd1;
    localparam logic [3:0] T1    = 4'd2;
    localparam logic [3:0] T2    = 4'd3;
    localparam logic [3:0] T3    = 4'd4;
    localparam logic [3:0] T4    = 4'd5;
    localparam logic [3:0] T5    = 4'd6;
    localparam logic [3:0] T6    = 4'd7;
    localparam logic [3:0] T7    = 4'd8;
    localparam logic [3:0] HALT  = 4'd9;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01010;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_BRX  = 5'b10011;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    logic [3:0]      state;
    logic [3:0]      nextState;
    logic [3:0]      boundaryState;
    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] immOp;
    logic            isLd, isLdi, isSt, isAlu, isImm, isMulDiv, isBrx, isJr, isHalt;
    logic            unusedIrBits;

    // Register fields are decoded downstream; only the opcode is used here.
    assign unusedIrBits = ^IR[26:0];

    // Instruction class decode of the latched opcode; anything unlisted is a nop.
    assign isLd     = (opcode == OP_LD);
    assign isLdi    = (opcode == OP_LDI);
    assign isSt     = (opcode == OP_ST);
    assign isAlu    = (opcode >= OP_ADD) && (opcode <= OP_ROL);
    assign isImm    = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign isMulDiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign isBrx    = (opcode == OP_BRX);
    assign isJr     = (opcode == OP_JR);
    assign isHalt   = (opcode == OP_HALT);

    // Instruction boundary: stop is honoured only here, so an in-flight instruction completes.
    assign boundaryState = stop ? HALT : T0;

    // ALU code for immediate forms.
    always_comb begin
        immOp = OP_OR;
        case (opcode)
            OP_ADDI: immOp = OP_ADD;
            OP_ANDI: immOp = OP_AND;
            default: immOp = OP_OR;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= RESET;
        end else begin
            state <= nextState;
        end
    end

    // Opcode latch on the T2->T3 edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            opcode <= '0;
        end else if (state == T2) begin
            opcode <= IR[31:27];
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        nextState = state;
        PCout = 1'b0; ZHighout = 1'b0; ZLowout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
        LOout = 1'b0; Cout = 1'b0; BAout = 1'b0; Rout = 1'b0;
        PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0; ZHIin = 1'b0;
        ZLOin = 1'b0; HIin = 1'b0; LOin = 1'b0; CONin = 1'b0; Rin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
        operation = '0;
        Run = (state != RESET) && (state != HALT);

        case (state)
            RESET: nextState = boundaryState;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1;
                nextState = T1;
            end
            T1: begin
                ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                if (mem_done) nextState = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                nextState = T3;
            end
            T3: begin
                nextState = T4;
                if (isAlu || isImm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (isLdi || isLd || isSt) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (isMulDiv) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (isBrx) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else if (isJr) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                    nextState = boundaryState;
                end else if (isHalt) begin
                    nextState = HALT;
                end else begin
                    nextState = boundaryState;
                end
            end
            T4: begin
                nextState = T5;
                if (isAlu) begin
                    Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; operation = opcode;
                end else if (isImm) begin
                    Cout = 1'b1; ZLOin = 1'b1; operation = immOp;
                end else if (isLdi || isLd || isSt) begin
                    Cout = 1'b1; ZLOin = 1'b1; operation = OP_ADD;
                end else if (isMulDiv) begin
                    Grb = 1'b1; Rout = 1'b1; ZHIin = 1'b1; ZLOin = 1'b1; operation = opcode;
                end else if (isBrx) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else begin
                    nextState = boundaryState;
                end
            end
            T5: begin
                nextState = T6;
                if (isAlu || isImm || isLdi) begin
                    ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    nextState = boundaryState;
                end else if (isLd || isSt) begin
                    ZLowout = 1'b1; MARin = 1'b1;
                end else if (isMulDiv) begin
                    ZLowout = 1'b1; LOin = 1'b1;
                end else if (isBrx) begin
                    Cout = 1'b1; ZLOin = 1'b1; operation = OP_ADD;
                end else begin
                    nextState = boundaryState;
                end
            end
            T6: begin
                nextState = boundaryState;
                if (isLd) begin
                    Read = 1'b1; MDRin = 1'b1;
                    nextState = mem_done ? T7 : T6;
                end else if (isSt) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    nextState = T7;
                end else if (isMulDiv) begin
                    ZHighout = 1'b1; HIin = 1'b1;
                end else if (isBrx) begin
                    ZLowout = 1'b1; PCin = CON_FF;
                end
            end
            T7: begin
                nextState = boundaryState;
                if (isLd) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (isSt) begin
                    Write = 1'b1;
                    if (!mem_done) nextState = T7;
                end
            end
            HALT: nextState = HALT;
            default: nextState = RESET;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven per-cycle check of every control_unit strobe,
// plus hand-written reset, halt-recovery and clr-during-wait sequences.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic        stop;
    logic [31:0] IR;
    logic        CON_FF;
    logic        mem_done;
    logic PCout, ZHighout, ZLowout, MDRout, HIout, LOout, Cout, BAout, Rout;
    logic PCin, IRin, MARin, MDRin, Yin, ZHIin, ZLOin, HIin, LOin, CONin, Rin;
    logic Gra, Grb, Grc, IncPC, Read, Write, Run;
    logic [4:0] operation;

    int checks = 0;
    int fails  = 0;

    // Strobe bit masks within the observed 32-bit vector.
    localparam logic [31:0] kRun      = 32'h0000_0001;
    localparam logic [31:0] kWrite    = 32'h0000_0040;
    localparam logic [31:0] kRead     = 32'h0000_0080;
    localparam logic [31:0] kIncPC    = 32'h0000_0100;
    localparam logic [31:0] kGrc      = 32'h0000_0200;
    localparam logic [31:0] kGrb      = 32'h0000_0400;
    localparam logic [31:0] kGra      = 32'h0000_0800;
    localparam logic [31:0] kRin      = 32'h0000_1000;
    localparam logic [31:0] kCONin    = 32'h0000_2000;
    localparam logic [31:0] kLOin     = 32'h0000_4000;
    localparam logic [31:0] kHIin     = 32'h0000_8000;
    localparam logic [31:0] kZLOin    = 32'h0001_0000;
    localparam logic [31:0] kZHIin    = 32'h0002_0000;
    localparam logic [31:0] kYin      = 32'h0004_0000;
    localparam logic [31:0] kMDRin    = 32'h0008_0000;
    localparam logic [31:0] kMARin    = 32'h0010_0000;
    localparam logic [31:0] kIRin     = 32'h0020_0000;
    localparam logic [31:0] kPCin     = 32'h0040_0000;
    localparam logic [31:0] kRout     = 32'h0080_0000;
    localparam logic [31:0] kBAout    = 32'h0100_0000;
    localparam logic [31:0] kCout     = 32'h0200_0000;
    localparam logic [31:0] kMDRout   = 32'h1000_0000;
    localparam logic [31:0] kZLowout  = 32'h2000_0000;
    localparam logic [31:0] kZHighout = 32'h4000_0000;
    localparam logic [31:0] kPCout    = 32'h8000_0000;

    localparam logic [31:0] kF0 = kPCout | kMARin | kIncPC | kZLOin | kRun;
    localparam logic [31:0] kF1 = kZLowout | kPCin | kRead | kMDRin | kRun;
    localparam logic [31:0] kF2 = kMDRout | kIRin | kRun;

    localparam logic [31:0] irAdd  = 32'h1800_0000;
    localparam logic [31:0] irLd   = 32'h0000_0000;
    localparam logic [31:0] irSt   = 32'h1000_0000;
    localparam logic [31:0] irBrx  = 32'h9800_0000;
    localparam logic [31:0] irOri  = 32'h7000_0000;
    localparam logic [31:0] irJr   = 32'hA000_0000;
    localparam logic [31:0] irBad  = 32'hF800_0000;
    localparam logic [31:0] irMul  = 32'h7800_0000;
    localparam logic [31:0] irHalt = 32'hD800_0000;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        md;
        logic        cf;
        logic        st;
        logic [31:0] exp;
    } vecT;

    vecT vecs[$];

    logic [31:0] obs;
    assign obs = {PCout, ZHighout, ZLowout, MDRout, HIout, LOout, Cout, BAout, Rout,
                  PCin, IRin, MARin, MDRin, Yin, ZHIin, ZLOin, HIin, LOin, CONin, Rin,
                  Gra, Grb, Grc, IncPC, Read, Write, operation, Run};

    control_unit dut (
        .clk(clk), .clr(clr), .stop(stop), .IR(IR), .CON_FF(CON_FF), .mem_done(mem_done),
        .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
        .ZHIin(ZHIin), .ZLOin(ZLOin), .HIin(HIin), .LOin(LOin), .CONin(CONin), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
        .operation(operation), .Run(Run)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] opField(input logic [4:0] o);
        return 32'(o) << 1;
    endfunction

    function void addVec(input string nm, input logic [31:0] ir, input logic md,
                         input logic cf, input logic st, input logic [31:0] exp);
        vecT v;
        v.name = nm; v.ir = ir; v.md = md; v.cf = cf; v.st = st; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: strobes got %h expected %h (t=%0t)", nm, obs, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check the Moore outputs of that cycle.
    task automatic step(input string nm, input logic [31:0] ir, input logic md,
                        input logic cf, input logic st, input logic [31:0] exp);
        @(negedge clk);
        IR = ir; mem_done = md; CON_FF = cf; stop = st;
        #1 check(nm, exp);
    endtask

    initial begin
        clr = 1'b0; stop = 1'b0; IR = '0; CON_FF = 1'b0; mem_done = 1'b1;

        // add; IR switched to halt after T2 to prove the opcode was latched
        addVec("add_T0", irAdd, 1, 0, 0, kF0);
        addVec("add_T1", irAdd, 1, 0, 0, kF1);
        addVec("add_T2", irAdd, 1, 0, 0, kF2);
        addVec("add_T3", irHalt, 1, 0, 0, kGrb | kRout | kYin | kRun);
        addVec("add_T4", irHalt, 1, 0, 0, kGrc | kRout | kZLOin | opField(5'b00011) | kRun);
        addVec("add_T5", irHalt, 1, 0, 0, kZLowout | kGra | kRin | kRun);
        // ld with three wait cycles in T6
        addVec("ld_T0", irLd, 1, 0, 0, kF0);
        addVec("ld_T1", irLd, 1, 0, 0, kF1);
        addVec("ld_T2", irLd, 1, 0, 0, kF2);
        addVec("ld_T3", irLd, 1, 0, 0, kGrb | kBAout | kYin | kRun);
        addVec("ld_T4", irLd, 1, 0, 0, kCout | kZLOin | opField(5'b00011) | kRun);
        addVec("ld_T5", irLd, 1, 0, 0, kZLowout | kMARin | kRun);
        addVec("ld_T6w1", irLd, 0, 0, 0, kRead | kMDRin | kRun);
        addVec("ld_T6w2", irLd, 0, 0, 0, kRead | kMDRin | kRun);
        addVec("ld_T6w3", irLd, 0, 0, 0, kRead | kMDRin | kRun);
        addVec("ld_T6", irLd, 1, 0, 0, kRead | kMDRin | kRun);
        addVec("ld_T7", irLd, 1, 0, 0, kMDRout | kGra | kRin | kRun);
        // brx taken
        addVec("brx1_T0", irBrx, 1, 1, 0, kF0);
        addVec("brx1_T1", irBrx, 1, 1, 0, kF1);
        addVec("brx1_T2", irBrx, 1, 1, 0, kF2);
        addVec("brx1_T3", irBrx, 1, 1, 0, kGra | kRout | kCONin | kRun);
        addVec("brx1_T4", irBrx, 1, 1, 0, kPCout | kYin | kRun);
        addVec("brx1_T5", irBrx, 1, 1, 0, kCout | kZLOin | opField(5'b00011) | kRun);
        addVec("brx1_T6", irBrx, 1, 1, 0, kZLowout | kPCin | kRun);
        // brx not taken
        addVec("brx0_T0", irBrx, 1, 0, 0, kF0);
        addVec("brx0_T1", irBrx, 1, 0, 0, kF1);
        addVec("brx0_T2", irBrx, 1, 0, 0, kF2);
        addVec("brx0_T3", irBrx, 1, 0, 0, kGra | kRout | kCONin | kRun);
        addVec("brx0_T4", irBrx, 1, 0, 0, kPCout | kYin | kRun);
        addVec("brx0_T5", irBrx, 1, 0, 0, kCout | kZLOin | opField(5'b00011) | kRun);
        addVec("brx0_T6", irBrx, 1, 0, 0, kZLowout | kRun);
        // ori
        addVec("ori_T0", irOri, 1, 0, 0, kF0);
        addVec("ori_T1", irOri, 1, 0, 0, kF1);
        addVec("ori_T2", irOri, 1, 0, 0, kF2);
        addVec("ori_T3", irOri, 1, 0, 0, kGrb | kRout | kYin | kRun);
        addVec("ori_T4", irOri, 1, 0, 0, kCout | kZLOin | opField(5'b00110) | kRun);
        addVec("ori_T5", irOri, 1, 0, 0, kZLowout | kGra | kRin | kRun);
        // jr with one fetch wait cycle
        addVec("jr_T0", irJr, 1, 0, 0, kF0);
        addVec("jr_T1w", irJr, 0, 0, 0, kF1);
        addVec("jr_T1", irJr, 1, 0, 0, kF1);
        addVec("jr_T2", irJr, 1, 0, 0, kF2);
        addVec("jr_T3", irJr, 1, 0, 0, kGra | kRout | kPCin | kRun);
        // undefined opcode runs as nop
        addVec("nop_T0", irBad, 1, 0, 0, kF0);
        addVec("nop_T1", irBad, 1, 0, 0, kF1);
        addVec("nop_T2", irBad, 1, 0, 0, kF2);
        addVec("nop_T3", irBad, 1, 0, 0, kRun);
        // mul with stop raised from T4: completes, then HALT
        addVec("mul_T0", irMul, 1, 0, 0, kF0);
        addVec("mul_T1", irMul, 1, 0, 0, kF1);
        addVec("mul_T2", irMul, 1, 0, 0, kF2);
        addVec("mul_T3", irMul, 1, 0, 0, kGra | kRout | kYin | kRun);
        addVec("mul_T4", irMul, 1, 0, 1, kGrb | kRout | kZHIin | kZLOin | opField(5'b01111) | kRun);
        addVec("mul_T5", irMul, 1, 0, 1, kZLowout | kLOin | kRun);
        addVec("mul_T6", irMul, 1, 0, 1, kZHighout | kHIin | kRun);
        for (int i = 0; i < 10; i++) addVec("halt_hold", irAdd, 1, 0, 0, 32'h0);

        // Reset held three cycles, then released
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("reset_hold", 32'h0);
        end
        @(negedge clk);
        clr = 1'b1;
        #1 check("reset_release", 32'h0);

        foreach (vecs[i]) step(vecs[i].name, vecs[i].ir, vecs[i].md, vecs[i].cf, vecs[i].st, vecs[i].exp);

        // Recovery from HALT through clr
        @(negedge clk);
        clr = 1'b0;
        #1 check("halt_clr", 32'h0);
        @(negedge clk);
        clr = 1'b1;
        #1 check("halt_release", 32'h0);

        // st, aborted by clr during the T7 wait
        step("st_T0", irSt, 1, 0, 0, kF0);
        step("st_T1", irSt, 1, 0, 0, kF1);
        step("st_T2", irSt, 1, 0, 0, kF2);
        step("st_T3", irSt, 1, 0, 0, kGrb | kBAout | kYin | kRun);
        step("st_T4", irSt, 1, 0, 0, kCout | kZLOin | opField(5'b00011) | kRun);
        step("st_T5", irSt, 1, 0, 0, kZLowout | kMARin | kRun);
        step("st_T6", irSt, 1, 0, 0, kGra | kRout | kMDRin | kRun);
        step("st_T7w1", irSt, 0, 0, 0, kWrite | kRun);
        step("st_T7w2", irSt, 0, 0, 0, kWrite | kRun);
        #1 clr = 1'b0;
        #1 check("st_clr_async", 32'h0);
        step("st_clr_held", irSt, 1, 0, 0, 32'h0);
        @(negedge clk);
        clr = 1'b1;
        #1 check("st_clr_release", 32'h0);
        step("refetch_T0", irHalt, 1, 0, 0, kF0);
        step("halt_T1", irHalt, 1, 0, 0, kF1);
        step("halt_T2", irHalt, 1, 0, 0, kF2);
        step("halt_T3", irHalt, 1, 0, 0, kRun);
        step("halt_state1", irAdd, 1, 0, 0, 32'h0);
        step("halt_state2", irAdd, 1, 0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
